alu_operand_regfile: RTL and testbench
======================================

Name: alu_operand_regfile

Overview:
- 32-entry x 64-bit general-purpose register file for the single-cycle datapath; sits directly upstream of the ALU.
- Two combinational read ports drive the ALU A and B operands.
- One clocked write port accepts the writeback value (ALU C or memory load data).
- Register index 31 is the hardwired zero register (XZR): it always reads 0 and writes to it are discarded.

Parameters:
- DATA_W, 64, register and port data width; must match the ALU operand width.
- NUM_REGS, 32, number of architectural registers; must be a power of two.
- ADDR_W, 5, address width; equals log2(NUM_REGS).
- ZERO_REG, 31, index hardwired to zero; a value >= NUM_REGS disables the zero register.
- BYPASS, 1, 1 = a read of the address being written this cycle returns wr_data; 0 = returns the stored (old) value.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rd_addr_a  input  ADDR_W  read port A index.
- rd_data_a  output  DATA_W  read port A data; drives ALU input A.
- rd_addr_b  input  ADDR_W  read port B index.
- rd_data_b  output  DATA_W  read port B data; drives ALU input B.
- wr_en  input  1  write enable.
- wr_addr  input  ADDR_W  write index.
- wr_data  input  DATA_W  write data.

Behaviour:
- Reset: one clock only, synchronous and active-high. At a rising edge of clk with rst=1, every register is cleared to 0. wr_en is ignored on that edge (reset wins over a simultaneous write). From the following cycle, every read returns 0.
- Reset mid-operation: a rst pulse between writes clears all previously written values. A write asserted in the same cycle as rst is lost.
- Write: at a rising edge with rst=0 and wr_en=1, regs[wr_addr] <= wr_data. Writes with wr_en=0 change nothing. A write to ZERO_REG is discarded and no storage is modified.
- Read: combinational, zero-cycle latency.
  - rd_data_x = 0 if rd_addr_x == ZERO_REG.
  - Otherwise, if BYPASS=1, wr_en=1, rst=0 and wr_addr == rd_addr_x, rd_data_x = wr_data.
  - Otherwise rd_data_x = regs[rd_addr_x].
  - The zero-register check takes priority over bypass.
- Ports A and B are independent. Both may address the same register and then return identical data. Both may bypass in the same cycle.
- Write-then-read: a value written at edge N is visible through storage from the cycle after edge N onward, regardless of BYPASS.
- Read-during-write:
  - BYPASS=0: the read returns the old stored value until the edge.
  - BYPASS=1: the read returns the new value in the same cycle.
  - While rst=1, bypass is suppressed and the read returns stored contents.
- Addresses: the full ADDR_W range is valid. With NUM_REGS=32 no address is out of range, so no wrap or clamp logic is needed.
- Storage width: all DATA_W bits are stored. No sign or zero extension and no truncation is applied.
- No X propagation: after reset, every output is a defined value for any defined input combination.
- Area/timing: the storage array is NUM_REGS x DATA_W flops (or an inferred RAM with 2R/1W), plus two read muxes and the bypass comparators. It lies on the single-cycle critical path (rd_addr -> ALU -> writeback), so no extra register stages are added.

Test Plan:
- Reset clear: write X1=0xFFFF_FFFF_FFFF_FFFF, pulse rst for 1 cycle, read A=X1, B=X2 -> rd_data_a=0, rd_data_b=0.
- ALU operand feed: write X1=0x5, then X2=0x3; read A=X1, B=X2 -> rd_data_a=0x5, rd_data_b=0x3. The downstream ALU with ctrl=000 then gives C=0x8.
- Zero register: write X31=0xDEAD_BEEF; read A=X31, B=X31 -> both 0. Also read X31 in the same cycle as a write to X31 with BYPASS=1 -> still 0.
- Bypass: BYPASS=1, X4 holds 0xAAAA_AAAA; in one cycle set wr_en=1, wr_addr=4, wr_data=0x5555_5555 and read A=X4 -> rd_data_a=0x5555_5555 before the edge. Repeat with BYPASS=0 -> 0xAAAA_AAAA before the edge, 0x5555_5555 after it.
- Reset vs write collision: rst=1 with wr_en=1, wr_addr=7, wr_data=0x1234 -> next cycle X7=0. During rst=1, a read of X7 does not bypass 0x1234.
- Random regression: 10k cycles of random reads/writes checked against a reference array model. Covers wr_en=0 holds, dual-port same-address reads, and back-to-back writes to the same register (the last write wins).

Source files
------------

// File: rtl/alu_operand_regfile.sv
// alu_operand_regfile: general-purpose register file feeding the ALU operands.
// Two combinational read ports (A/B), one clocked write port, an optional
// hardwired zero register and an optional write-to-read bypass.
module alu_operand_regfile #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  // An out-of-range ZERO_REG value turns the zero register off entirely.
  localparam bit                ZERO_EN   = (ZERO_REG < NUM_REGS);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam bit                BYP_EN    = (BYPASS != 0);

  logic [DATA_W-1:0] regs_r [NUM_REGS];

  logic              wr_hits_zero_s;
  logic              wr_commit_s;
  logic              byp_ok_s;
  logic [DATA_W-1:0] stored_a_s;
  logic [DATA_W-1:0] stored_b_s;

  // Read-port selection: zero register beats bypass, bypass beats storage.
  function automatic logic [DATA_W-1:0] read_mux(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              byp_ok,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] val;
    if (ZERO_EN && (addr == ZERO_ADDR)) begin
      val = '0;
    end else if (byp_ok && (addr == waddr)) begin
      val = wdata;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  assign wr_hits_zero_s = ZERO_EN && (wr_addr == ZERO_ADDR);
  assign wr_commit_s    = wr_en && !wr_hits_zero_s;
  // Bypass is suppressed while reset is asserted: the write is being dropped.
  assign byp_ok_s       = BYP_EN && wr_en && !rst;
  assign stored_a_s     = regs_r[rd_addr_a];
  assign stored_b_s     = regs_r[rd_addr_b];

  // Storage update: synchronous clear wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wr_commit_s) begin
      regs_r[wr_addr] <= wr_data;
    end
  end

  // Zero-latency operand read for both ALU inputs.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    rd_data_a = read_mux(rd_addr_a, stored_a_s, byp_ok_s, wr_addr, wr_data);
    rd_data_b = read_mux(rd_addr_b, stored_b_s, byp_ok_s, wr_addr, wr_data);
  end

endmodule

// File: tb/tb_alu_operand_regfile.sv
// Self-checking bench for alu_operand_regfile. Two instances share all inputs:
// dut (BYPASS=1) and dut_nb (BYPASS=0). Expected read data for both is pushed
// to a scoreboard queue when stimulus is driven and popped when sampled.
module tb_alu_operand_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [63:0] wr_data;
  logic [63:0] rd_data_a, rd_data_b, nb_data_a, nb_data_b;

  logic [63:0]  model [32];
  logic [255:0] exp_q [$];
  logic [255:0] got, exp_v;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_operand_regfile #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  alu_operand_regfile #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_data_a(nb_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(nb_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // Reference read behaviour for the current inputs.
  function automatic logic [63:0] ref_read(input logic [4:0] addr, input bit byp);
    if (addr == 5'd31) return 64'd0;
    if (byp && wr_en && !rst && (wr_addr == addr)) return wr_data;
    return model[addr];
  endfunction

  // Push the expected {A, B, A_nobypass, B_nobypass} for the driven inputs.
  task automatic push_exp();
    exp_q.push_back({ref_read(rd_addr_a, 1'b1), ref_read(rd_addr_b, 1'b1),
                     ref_read(rd_addr_a, 1'b0), ref_read(rd_addr_b, 1'b0)});
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 64'd0;
    end else if (wr_en && (wr_addr != 5'd31)) begin
      model[wr_addr] = wr_data;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                       input logic [63:0] wd, input logic [4:0] ra, input logic [4:0] rb);
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr_a = ra; rd_addr_b = rb;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 5'd0, 64'd0, 5'd1, 5'd2);
    tick();
    drive(1'b0, 1'b1, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 5'd2);
    tick();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd1, 5'd2);
    push_exp(); #1;
    got = {rd_data_a, rd_data_b, nb_data_a, nb_data_b}; exp_v = exp_q.pop_front(); total++;
    if (got !== exp_v) begin bad++; $display("FAIL reset_prewrite got=%h exp=%h", got, exp_v); end
    drive(1'b1, 1'b0, 5'd0, 64'd0, 5'd1, 5'd2);
    tick();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd1, 5'd2);
    push_exp(); #1;
    got = {rd_data_a, rd_data_b, nb_data_a, nb_data_b}; exp_v = exp_q.pop_front(); total++;
    if (got !== exp_v || got !== 256'd0) begin bad++; $display("FAIL reset_clear got=%h exp=%h", got, exp_v); end
    for (int i = 0; i < 31; i += 2) begin
      drive(1'b0, 1'b0, 5'd0, 64'd0, 5'(i), 5'(i + 1));
      push_exp(); #1;
      got = {rd_data_a, rd_data_b, nb_data_a, nb_data_b}; exp_v = exp_q.pop_front(); total++;
      if (got !== 256'd0) begin bad++; $display("FAIL reset_all i=%0d got=%h exp=%h", i, got, exp_v); end
      @(negedge clk);
    end
  endtask

  task automatic test_operand_feed();
    drive(1'b0, 1'b1, 5'd1, 64'h5, 5'd1, 5'd2);
    tick();
    drive(1'b0, 1'b1, 5'd2, 64'h3, 5'd1, 5'd2);
    tick();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd1, 5'd2);
    push_exp(); #1;
    got = {rd_data_a, rd_data_b, nb_data_a, nb_data_b}; exp_v = exp_q.pop_front(); total++;
    if (got !== exp_v || rd_data_a !== 64'h5 || rd_data_b !== 64'h3) begin
      bad++; $display("FAIL operand_feed got=%h exp=%h", got, exp_v);
    end
    total++;
    if (rd_data_a + rd_data_b !== 64'h8) begin
      bad++; $display("FAIL operand_sum got=%h exp=%h", rd_data_a + rd_data_b, 64'h8);
    end
  endtask

  task automatic test_zero_reg();
    drive(1'b0, 1'b1, 5'd31, 64'hDEAD_BEEF, 5'd31, 5'd31);
    push_exp(); #1;
    got = {rd_data_a, rd_data_b, nb_data_a, nb_data_b}; exp_v = exp_q.pop_front(); total++;
    if (got !== exp_v || got !== 256'd0) begin bad++; $display("FAIL zero_bypass got=%h exp=%h", got, exp_v); end
    tick();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd31, 5'd31);
    push_exp(); #1;
    got = {rd_data_a, rd_data_b, nb_data_a, nb_data_b}; exp_v = exp_q.pop_front(); total++;
    if (got !== exp_v || got !== 256'd0) begin bad++; $display("FAIL zero_stored got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_bypass();
    drive(1'b0, 1'b1, 5'd4, 64'hAAAA_AAAA, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b1, 5'd4, 64'h5555_5555, 5'd4, 5'd4);
    push_exp(); #1;
    got = {rd_data_a, rd_data_b, nb_data_a, nb_data_b}; exp_v = exp_q.pop_front(); total++;
    if (got !== exp_v || rd_data_a !== 64'h5555_5555 || nb_data_a !== 64'hAAAA_AAAA) begin
      bad++; $display("FAIL bypass_same_cycle got=%h exp=%h", got, exp_v);
    end
    tick();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd4, 5'd4);
    push_exp(); #1;
    got = {rd_data_a, rd_data_b, nb_data_a, nb_data_b}; exp_v = exp_q.pop_front(); total++;
    if (got !== exp_v || nb_data_a !== 64'h5555_5555) begin
      bad++; $display("FAIL bypass_after_edge got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_rst_collision();
    drive(1'b0, 1'b1, 5'd7, 64'h77, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b1, 5'd7, 64'h1234, 5'd7, 5'd7);
    push_exp(); #1;
    got = {rd_data_a, rd_data_b, nb_data_a, nb_data_b}; exp_v = exp_q.pop_front(); total++;
    if (got !== exp_v || rd_data_a !== 64'h77) begin
      bad++; $display("FAIL rst_no_bypass got=%h exp=%h", got, exp_v);
    end
    tick();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd7, 5'd7);
    push_exp(); #1;
    got = {rd_data_a, rd_data_b, nb_data_a, nb_data_b}; exp_v = exp_q.pop_front(); total++;
    if (got !== exp_v || got !== 256'd0) begin bad++; $display("FAIL rst_wins got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 1'b1, 5'd9, 64'(k * 64'h1111), 5'd9, 5'd10);
      push_exp(); #1;
      got = {rd_data_a, rd_data_b, nb_data_a, nb_data_b}; exp_v = exp_q.pop_front(); total++;
      if (got !== exp_v) begin bad++; $display("FAIL back_to_back k=%0d got=%h exp=%h", k, got, exp_v); end
      tick();
    end
    drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd9, 5'd9);
    push_exp(); #1;
    got = {rd_data_a, rd_data_b, nb_data_a, nb_data_b}; exp_v = exp_q.pop_front(); total++;
    if (got !== exp_v || rd_data_a !== 64'h3333) begin bad++; $display("FAIL last_write_wins got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_random();
    logic [4:0] ra, rb, wa;
    for (int n = 0; n < 10000; n++) begin
      wa = 5'($urandom_range(31, 0));
      ra = ($urandom_range(3, 0) == 0) ? wa : 5'($urandom_range(31, 0));
      rb = ($urandom_range(3, 0) == 0) ? ra : 5'($urandom_range(31, 0));
      drive(($urandom_range(127, 0) == 0), 1'($urandom_range(1, 0)), wa,
            {32'($urandom), 32'($urandom)}, ra, rb);
      push_exp(); #1;
      got = {rd_data_a, rd_data_b, nb_data_a, nb_data_b}; exp_v = exp_q.pop_front(); total++;
      if (got !== exp_v) begin
        bad++;
        $display("FAIL random n=%0d ra=%0d rb=%0d got=%h exp=%h", n, ra, rb, got, exp_v);
      end
      tick();
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) model[i] = 64'd0;
    @(negedge clk);
    test_reset();
    test_operand_feed();
    test_zero_reg();
    test_bypass();
    test_rst_collision();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Time bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
